// File: rtl/alu_op_sequencer.sv
// Multi-cycle control sequencer for the 16-bit register-file/ALU datapath.
// Runs native ALU ops plus compare, repeated shift-left and NOP macro-ops.
//
// state | meaning
// IDLE  | ready for a command; latches it on cmd_valid
// EXEC  | drives the datapath; one cycle, or cnt cycles for the shift macro
// DONE  | one-cycle retire pulse, then back to IDLE
module alu_op_sequencer #(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_srca,
  input  logic [ADDR_W-1:0] cmd_srcb,
  input  logic [CNT_W-1:0]  cmd_cnt,
  output logic [ADDR_W-1:0] R_Adr,
  output logic [ADDR_W-1:0] S_Adr,
  output logic [ADDR_W-1:0] W_Adr,
  output logic              W_En,
  output logic [3:0]        Alu_Op,
  input  logic              N_in,
  input  logic              Z_in,
  input  logic              C_in,
  output logic              N,
  output logic              Z,
  output logic              C,
  output logic              busy,
  output logic              done
);

  localparam logic [3:0] OP_CMP   = 4'hD;
  localparam logic [3:0] OP_SHL   = 4'hE;
  localparam logic [3:0] OP_NOP   = 4'hF;
  localparam logic [3:0] ALU_SUB  = 4'h5;
  localparam logic [3:0] ALU_SHL1 = 4'h7;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t              state_q;
  logic [3:0]          op_q;
  logic [ADDR_W-1:0]   dst_q, srca_q, srcb_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                first_q;
  logic                n_q, z_q, c_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      dst_q   <= '0;
      srca_q  <= '0;
      srcb_q  <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            dst_q   <= cmd_dst;
            srca_q  <= cmd_srca;
            srcb_q  <= cmd_srcb;
            cnt_q   <= cmd_cnt;
            first_q <= 1'b1;
            if (cmd_op == OP_NOP || (cmd_op == OP_SHL && cmd_cnt == '0))
              state_q <= DONE;
            else
              state_q <= EXEC;
          end
        end
        EXEC: begin
          n_q <= N_in;
          z_q <= Z_in;
          c_q <= C_in;
          if (op_q == OP_SHL) begin
            first_q <= 1'b0;
            cnt_q   <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
              state_q <= DONE;
          end else begin
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath controls are pure decodes of state so reset kills W_En at once.
  always_comb begin
    R_Adr     = '0;
    S_Adr     = '0;
    W_Adr     = '0;
    W_En      = 1'b0;
    Alu_Op    = 4'h0;
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    if (state_q == EXEC) begin
      R_Adr = srca_q;
      W_Adr = dst_q;
      case (op_q)
        OP_CMP: begin
          Alu_Op = ALU_SUB;
          S_Adr  = srcb_q;
        end
        OP_SHL: begin
          Alu_Op = ALU_SHL1;
          S_Adr  = first_q ? srcb_q : dst_q;
          W_En   = 1'b1;
        end
        default: begin
          Alu_Op = op_q;
          S_Adr  = srcb_q;
          W_En   = 1'b1;
        end
      endcase
    end
  end

  assign N = n_q;
  assign Z = z_q;
  assign C = c_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle control sequencer for the 16-bit integer datapath (8x16 register file feeding the alu16 R/S inputs, with Y written back).
- Accepts one command at a time over a valid/ready handshake.
- Drives the register-file addresses, write enable and Alu_Op, and latches the ALU N/Z/C outputs into a status register.
- Adds three sequenced macro-ops (compare, repeated shift-left, NOP) in the unused Alu_Op codes D–F.

Parameters:
- ADDR_W, 3, register-file address width (8 registers)
- CNT_W, 4, width of the repeat count for the shift macro

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  a command is presented
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
- cmd_op  in  4  0x0–0xC: native ALU op; 0xD: compare; 0xE: shift-left macro; 0xF: NOP
- cmd_dst  in  ADDR_W  destination register
- cmd_srca  in  ADDR_W  R-operand register
- cmd_srcb  in  ADDR_W  S-operand register
- cmd_cnt  in  CNT_W  shift count for op 0xE; ignored otherwise
- R_Adr  out  ADDR_W  register-file read port to ALU R
- S_Adr  out  ADDR_W  register-file read port to ALU S
- W_Adr  out  ADDR_W  register-file write address
- W_En  out  1  register-file write enable (Y written on the clk edge)
- Alu_Op  out  4  ALU operation select
- N_in, Z_in, C_in  in  1 each  live ALU flag outputs
- N, Z, C  out  1 each  latched status flags
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a command retires

Behaviour:
- States: IDLE, EXEC, DONE.
- All outputs are decoded combinationally from registered state.
- While reset is low:
  - state = IDLE; latched command, iteration counter and N/Z/C are cleared to 0.
  - W_En, Alu_Op, all addresses, busy and done are 0.
  - cmd_ready reads 1, but no command is accepted until reset is released.
- Reset asserted mid-command: W_En drops to 0 immediately (asynchronously), the command is discarded and no further write occurs.
- IDLE:
  - cmd_ready = 1.
  - On a clk edge with cmd_valid = 1, latch op, dst, srca, srcb and cnt.
  - Next state is DONE for op 0xF, or for op 0xE with cnt = 0; otherwise EXEC.
  - cmd_ready is low from the accepting edge until the return to IDLE.
- EXEC, ops 0x0–0xC (one cycle):
  - R_Adr = srca, S_Adr = srcb, Alu_Op = op, W_Adr = dst, W_En = 1.
  - At the edge: N/Z/C <= N_in/Z_in/C_in; next state DONE.
- EXEC, op 0xD (compare): as above, but Alu_Op = 0x5 and W_En = 0. Only the flags update.
- EXEC, op 0xE (shift macro):
  - Alu_Op = 0x7, W_Adr = dst, W_En = 1.
  - S_Adr = srcb on the first iteration and dst on each later iteration.
  - Runs cnt iterations, one per cycle; an internal counter counts cnt down to 1.
  - Flags latch on every iteration, so the final value reflects the last shift.
  - Next state is DONE after the iteration where the counter equals 1.
- DONE:
  - done = 1 and busy = 1 for exactly one cycle; then IDLE.
- NOP, and shift with cnt = 0: no write; flags unchanged.
- Latency (accept edge = k):
  - Single op: write and flag latch at edge k+1; done high in cycle k+2; cmd_ready high again at k+3.
  - Shift macro: cnt+2 cycles from accept edge to ready.
- Back-to-back commands: one idle cycle minimum between done and the next accept.
- cmd_valid held high while busy: ignored, and not latched.

Test Plan:
- Bench instantiates alu16 plus a behavioural 8x16 register file.
- r1=D2D2, r2=2D2D; op 0x4, dst r3 → r3=FFFF; N=1, Z=0, C=0; done exactly 2 cycles after accept.
- r1=E1E1, r2=E1E1; op 0xD, dst r4 (r4 preloaded 1234) → Z=1; r4 still 1234; W_En never high.
- r2=0001; op 0xE, cnt=4, srcb r2, dst r5 → r5=0010; W_En high for exactly 4 consecutive cycles; done on the 5th cycle after accept.
- op 0xE with cnt=0, then op 0xF → no writes; flags unchanged; done after 1 cycle each.
- Reset pulsed low during the 2nd shift iteration of cnt=8 → W_En falls immediately; N=Z=C=0; IDLE; r5 holds the value from the 1st iteration only.
- cmd_valid held high with a new op while busy → second command accepted only after done; exactly one extra write observed.
